alu_operand_loader: RTL
=======================

Name: alu_operand_loader

Overview:
- Upstream operand sequencer for the ALU gate stage (ShiftLeft_gate, subtraction, AND, XOR).
- Captures operand A, operand B and an operation select from a shared N-bit switch bus, one field per press of a load button.
- Presents the captured fields as stable registered outputs, with op_valid flagging a complete set.
- Buttons are raw, asynchronous board inputs; the block synchronises them and edge-detects them internally.

Parameters:
- N, 6, operand width; width of data_in, A_num, B_num.
- OPW, 2, width of the operation select.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous active-low reset; 0 resets immediately, release is synchronous to clk.
- data_in  input  N  switch bus; sampled only on an internal load pulse.
- btn_load  input  1  raw load button, active-high, asynchronous to clk.
- btn_clear  input  1  raw clear button, active-high, asynchronous to clk.
- A_num  output  N  captured operand A; feeds the ALU stage A_num.
- B_num  output  N  captured operand B or shift amount; feeds the ALU stage B_num.
- op_sel  output  OPW  captured operation select.
- op_valid  output  1  high while A_num, B_num and op_sel form a complete set.
- state_out  output  2  current FSM state encoding, for LED display.

Behaviour:
- Reset (rst=0), asynchronous:
  - A_num=0, B_num=0, op_sel=0, op_valid=0.
  - FSM=WAIT_A, state_out=2'b00.
  - All synchroniser and edge flops cleared to 0.
- Input conditioning, identical for each button:
  - Three flops s1<=btn, s2<=s1, s3<=s2.
  - pulse = s2 & ~s3.
  - A button first sampled high at edge k gives a pulse that is high for exactly one cycle, between edges k+1 and k+2. The action commits at edge k+2.
  - A held button yields exactly one pulse. A press shorter than one clock period may be missed; this is acceptable.
- FSM states, with state_out encoding:
  - WAIT_A=00, WAIT_B=01, WAIT_OP=10, READY=11.
- FSM transitions on load_pulse (and no clear_pulse):
  - WAIT_A: A_num<=data_in; go to WAIT_B.
  - WAIT_B: B_num<=data_in; go to WAIT_OP.
  - WAIT_OP: op_sel<=data_in[OPW-1:0]; op_valid<=1; go to READY.
  - READY: op_valid<=0; go to WAIT_A. A_num, B_num and op_sel hold their values; no data is captured.
- With no pulse, every register holds.
- clear_pulse, in any state:
  - A_num, B_num, op_sel <= 0; op_valid<=0; FSM<=WAIT_A.
  - clear_pulse and load_pulse in the same cycle: clear wins and the load is discarded.
- Output timing:
  - Outputs are registered only; no combinational path from data_in or the buttons.
  - op_valid rises on the same edge that op_sel updates.
- Widths:
  - data_in is captured bit-exact, with no sign extension.
  - B_num is not range-checked; values of N or greater pass through unchanged, and the downstream stage defines the result.
  - data_in[N-1:OPW] are ignored in WAIT_OP.
  - OPW must be less than or equal to N.
- Reset mid-sequence returns to WAIT_A with all outputs 0. A button still held at reset release produces one pulse after release, because the synchroniser flops start at 0.
- Changes on data_in between pulses have no effect on any output.

Test Plan:
- Reset then release; no button activity for 10 cycles -> A_num=0, B_num=0, op_sel=0, op_valid=0, state_out=00 throughout.
- Three load presses with data_in=6'b001100, then 6'd2, then 6'b000001 -> A_num=001100, B_num=000010, op_sel=01. op_valid=1 and state_out=11 from the third commit edge onward.
- btn_load first sampled high at edge 5 and held for 20 cycles -> exactly one capture, at edge 7, with state_out going from 00 to 01 only. data_in toggling after edge 7 leaves A_num unchanged.
- Reach READY with A=000011, B=3; then press load -> op_valid falls and FSM returns to WAIT_A with A_num and B_num unchanged. The next press with 6'b111000 gives A_num=111000.
- In WAIT_OP (A=111000, B=2 loaded), assert btn_load and btn_clear together -> on the commit edge all outputs are 0, state_out=00, op_valid stays 0.
- Assert rst=0 asynchronously between edges while in WAIT_B -> outputs go to 0 immediately, without waiting for a clock edge. After release, the full three-press sequence completes normally.

Source files
------------

// File: rtl/alu_operand_loader_if.sv
// Switch bus, buttons and captured operand outputs of the ALU operand loader.
interface alu_operand_loader_if #(
    parameter int N   = 6,
    parameter int OPW = 2
);
    logic [N-1:0]   data_in;
    logic           btn_load;
    logic           btn_clear;
    logic [N-1:0]   A_num;
    logic [N-1:0]   B_num;
    logic [OPW-1:0] op_sel;
    logic           op_valid;
    logic [1:0]     state_out;

    // Board side: drives the switches and buttons, observes the captured set.
    modport master (
        output data_in, btn_load, btn_clear,
        input  A_num, B_num, op_sel, op_valid, state_out
    );

    // Loader side.
    modport slave (
        input  data_in, btn_load, btn_clear,
        output A_num, B_num, op_sel, op_valid, state_out
    );
endinterface

// File: rtl/alu_operand_loader.sv
// Operand sequencer for the ALU gate stage: captures A, B and the operation
// select from a shared switch bus, one field per load-button press.
//
// state   | meaning
// WAIT_A  | next load captures operand A
// WAIT_B  | next load captures operand B / shift amount
// WAIT_OP | next load captures the operation select and raises op_valid
// READY   | full set presented; next load drops op_valid, keeps the data
module alu_operand_loader #(
    parameter int N   = 6,
    parameter int OPW = 2
) (
    input logic                clk,
    input logic                rst,
    alu_operand_loader_if.slave bus
);
    typedef enum logic [1:0] {
        WAIT_A  = 2'b00,
        WAIT_B  = 2'b01,
        WAIT_OP = 2'b10,
        READY   = 2'b11
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     load_sync, clear_sync;
    logic           load_pulse, clear_pulse;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic [OPW-1:0] op_q, op_d;
    logic           valid_q, valid_d;

    // Two flops of synchronisation plus one history flop per button; the
    // rising edge of the synchronised level gives a single-cycle pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_sync  <= '0;
            clear_sync <= '0;
        end else begin
            load_sync  <= {load_sync[1:0], bus.btn_load};
            clear_sync <= {clear_sync[1:0], bus.btn_clear};
        end
    end

    assign load_pulse  = load_sync[1] & ~load_sync[2];
    assign clear_pulse = clear_sync[1] & ~clear_sync[2];

    // State and captured-field registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    // Next-state and capture decode; clear overrides a coincident load.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        valid_d = valid_q;
        if (clear_pulse) begin
            state_d = WAIT_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            valid_d = 1'b0;
        end else if (load_pulse) begin
            case (state_q)
                WAIT_A: begin
                    a_d     = bus.data_in;
                    state_d = WAIT_B;
                end
                WAIT_B: begin
                    b_d     = bus.data_in;
                    state_d = WAIT_OP;
                end
                WAIT_OP: begin
                    op_d    = bus.data_in[OPW-1:0];
                    valid_d = 1'b1;
                    state_d = READY;
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = WAIT_A;
                end
            endcase
        end
    end

    assign bus.A_num     = a_q;
    assign bus.B_num     = b_q;
    assign bus.op_sel    = op_q;
    assign bus.op_valid  = valid_q;
    assign bus.state_out = state_q;
endmodule
